i2c_reg_target: RTL and testbench
=================================

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h42, the 7-bit target address.
REQ-002 SHALL have parameter NUM_REGS, default 8, the register count; power of 2 only, range 2..256.
REQ-003 SHALL have parameter FILTER_LEN, default 3, the consecutive identical samples required to accept a new SCL/SDA level.
REQ-004 SHALL have port clk, input, 1 bit: system clock, at least 20x SCL rate.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port scl_i, input, 1 bit: raw bus SCL, asynchronous to clk.
REQ-007 SHALL have port sda_i, input, 1 bit: raw bus SDA, asynchronous to clk.
REQ-008 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open drain); the block never drives SCL.
REQ-009 SHALL have port host_we, input, 1 bit: fabric write strobe.
REQ-010 SHALL have port host_idx, input, $clog2(NUM_REGS) bits: fabric write index.
REQ-011 SHALL have port host_wdata, input, 8 bits: fabric write data.
REQ-012 SHALL have port regs_q, output, NUM_REGS*8 bits: flattened register file, reg k at bits [8k+7:8k].
REQ-013 SHALL have port wr_valid, output, 1 bit: one-clk pulse when the bus writes a register.
REQ-014 SHALL have port wr_idx, output, $clog2(NUM_REGS) bits: index written, valid with wr_valid.
REQ-015 SHALL have port busy, output, 1 bit: 1 from address match until STOP, or START to another address.

Function
REQ-016 SHALL pass SCL and SDA through a 2-flop synchroniser, then a FILTER_LEN glitch filter.
REQ-017 SHALL compute all edges from the filtered signals; input-to-edge latency is 2+FILTER_LEN clk.
REQ-018 SHALL detect START as filtered SDA falling while filtered SCL is high, and STOP as SDA rising while SCL is high.
REQ-019 SHALL sample SDA on filtered SCL rise and change sda_oe exactly 1 clk after filtered SCL fall.
REQ-020 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_CACK, WAIT.
REQ-021 START from any state SHALL go to ADDR with bit counter 0; a repeated START retains the pointer.
REQ-022 STOP from any state SHALL go to IDLE and deassert sda_oe and busy on the next clk.
REQ-023 ADDR SHALL shift 8 bits MSB first, then go to ADDR_ACK.
REQ-024 On address mismatch the block SHALL go to WAIT and leave sda_oe at 0 (NACK).
REQ-025 On address match the block SHALL drive ACK for the 9th clock.
REQ-026 After a matched ACK with R/W=0 the block SHALL go to PTR; with R/W=1 it SHALL go to RDATA.
REQ-027 PTR SHALL receive the pointer byte, ACK it, and store its low $clog2(NUM_REGS) bits.
REQ-028 After PTR every subsequent byte SHALL go to WDATA, be ACKed, and write regs[ptr].
REQ-029 Each WDATA write SHALL pulse wr_valid with wr_idx=ptr 1 clk after the 8th-bit SCL rise, then set ptr to ptr+1 mod NUM_REGS.
REQ-030 RDATA SHALL load regs[ptr] on the SCL fall that starts the byte, then increment ptr mod NUM_REGS.
REQ-031 RDATA SHALL shift the loaded byte out MSB first, driving sda_oe = ~bit.
REQ-032 RDATA_CACK SHALL release SDA; a sampled 0 (ACK) returns to RDATA and a sampled 1 (NACK) goes to WAIT.
REQ-033 WAIT SHALL ignore all bits until START or STOP.
REQ-034 host_we SHALL write regs[host_idx] on the clk edge.
REQ-035 When a host write and a bus write hit the same index in the same clk, the bus write SHALL win.
REQ-036 A read byte already loaded SHALL NOT change on a later host write.

Reset
REQ-037 rst SHALL force state IDLE, ptr 0, regs_q 0, sda_oe 0, wr_valid 0, wr_idx 0, busy 0.
REQ-038 rst SHALL preset the filter outputs and synchronisers to 1 (idle bus) so that no false START follows reset.
REQ-039 rst mid-transfer SHALL release SDA immediately; the block responds again only after a fresh START.

Structure
REQ-040 Shared package i2c_pkg SHALL hold the state enum i2c_tgt_state_t and constants ADDR_BITS=7, BYTE_BITS=8.
REQ-041 Sub-module i2c_glitch_filter (synchroniser plus FILTER_LEN counter, reset value parameter) SHALL be instantiated once each for SCL and SDA.

Verification
REQ-042 Write 0x84, 0x03, 0xAA, 0xBB, STOP -> regs[3]=0xAA, regs[4]=0xBB, two wr_valid pulses with wr_idx 3 then 4, all bytes ACKed.
REQ-043 Write 0x84, 0x07, 0x11, 0x22 (NUM_REGS=8) -> regs[7]=0x11, regs[0]=0x22 (pointer wrap).
REQ-044 Write 0x84, 0x02, repeated START, 0x85, read 2 bytes ACK then NACK, STOP -> returns regs[2] then regs[3]; SDA released after NACK.
REQ-045 Address 0x90 -> no ACK, sda_oe stays 0 through STOP, busy stays 0.
REQ-046 One-clk 0 glitch on SCL/SDA with FILTER_LEN=3 -> no edge or START detected; host_we and bus write to the same index in the same clk -> bus data retained.
REQ-047 Assert rst during the 4th data bit of a read -> sda_oe=0 next clk, regs_q=0; the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    localparam int unsigned ADDR_BITS = 7;
    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_CACK,
        WAIT
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a level filter that accepts a new level
// only after FILTER_LEN consecutive identical synchronised samples.
module i2c_glitch_filter #(
    parameter int unsigned FILTER_LEN = 3,
    parameter logic        RESET_VAL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned      CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Any sample agreeing with the current output restarts the run count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= RESET_VAL;
            sync_2 <= RESET_VAL;
            cnt    <= '0;
            dout   <= RESET_VAL;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                dout <= sync_2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a byte-wide register file: pointer byte then writes,
// or sequential reads from the pointer; host fabric may also write registers.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] ADDRESS    = 7'h42,
    parameter int unsigned          NUM_REGS   = 8,
    parameter int unsigned          FILTER_LEN = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          sda_oe,
    input  logic                          host_we,
    input  logic [$clog2(NUM_REGS)-1:0]   host_idx,
    input  logic [BYTE_BITS-1:0]          host_wdata,
    output logic [NUM_REGS*BYTE_BITS-1:0] regs_q,
    output logic                          wr_valid,
    output logic [$clog2(NUM_REGS)-1:0]   wr_idx,
    output logic                          busy
);

    localparam int unsigned          PTR_W    = $clog2(NUM_REGS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] ALL_BITS = BIT_CNT_W'(BYTE_BITS);

    logic scl_f, sda_f;
    logic scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    i2c_tgt_state_t state, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [BYTE_BITS-2:0] rx, rx_n;
    logic [BYTE_BITS-1:0] rx_byte;
    logic [BYTE_BITS-1:0] tx, tx_n;
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic                 rw, rw_n;
    logic                 sda_oe_n, busy_n, wr_valid_n;
    logic [PTR_W-1:0]     wr_idx_n;
    logic                 bus_we_c;
    logic                 load_rd;

    logic [BYTE_BITS-1:0] regs [NUM_REGS];
    logic [BYTE_BITS-1:0] rd_byte;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_scl_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (scl_i),
        .dout (scl_f)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_sda_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (sda_i),
        .dout (sda_f)
    );

    // Previous filtered levels; presetting high keeps reset from looking like a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    assign rx_byte = {rx, sda_f};
    assign rd_byte = regs[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_idx   <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx       <= rx_n;
            tx       <= tx_n;
            ptr      <= ptr_n;
            rw       <= rw_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            wr_valid <= wr_valid_n;
            wr_idx   <= wr_idx_n;
        end
    end

    // ACK phases use sda_oe itself to tell the first SCL fall (drive) from the second (release).
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_n       = rx;
        tx_n       = tx;
        ptr_n      = ptr;
        rw_n       = rw;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        wr_valid_n = 1'b0;
        wr_idx_n   = wr_idx;
        bus_we_c   = 1'b0;
        load_rd    = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        rx_n      = rx_byte[BYTE_BITS-2:0];
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n = '0;
                            rw_n      = sda_f;
                            if (rx == ADDRESS) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            if (rw) begin
                                state_n = RDATA;
                                load_rd = 1'b1;
                            end else begin
                                state_n = PTR;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        rx_n      = rx_byte[BYTE_BITS-2:0];
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n = '0;
                            ptr_n     = rx_byte[PTR_W-1:0];
                            state_n   = PTR_ACK;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        rx_n      = rx_byte[BYTE_BITS-2:0];
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n  = '0;
                            bus_we_c   = 1'b1;
                            wr_valid_n = 1'b1;
                            wr_idx_n   = ptr;
                            ptr_n      = ptr + PTR_W'(1);
                            state_n    = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt == '0) begin
                            load_rd = 1'b1;
                        end else if (bit_cnt == ALL_BITS) begin
                            sda_oe_n = 1'b0;
                            state_n  = RDATA_CACK;
                        end else begin
                            tx_n     = {tx[BYTE_BITS-2:0], tx[BYTE_BITS-1]};
                            sda_oe_n = ~tx[BYTE_BITS-2];
                        end
                    end
                end
                RDATA_CACK: begin
                    if (scl_rise) begin
                        bit_cnt_n = '0;
                        state_n   = sda_f ? WAIT : RDATA;
                    end
                end
                IDLE, WAIT: begin
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        // Snapshot the read byte so later host writes cannot alter it mid-shift.
        if (load_rd) begin
            tx_n      = rd_byte;
            sda_oe_n  = ~rd_byte[BYTE_BITS-1];
            ptr_n     = ptr + PTR_W'(1);
            bit_cnt_n = '0;
        end
    end

    // Bus write is applied last so it wins a same-index collision with the host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else begin
            if (host_we) begin
                regs[host_idx] <= host_wdata;
            end
            if (bus_we_c) begin
                regs[ptr] <= rx_byte;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_q[k*BYTE_BITS +: BYTE_BITS] = regs[k];
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged bus master with scoreboard
// queues for expected register writes and read bytes.
module tb_i2c_reg_target;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned Q        = 25;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  scl_m = 1'b1;
    logic                  sda_m = 1'b1;
    logic                  sda_line;
    logic                  sda_oe;
    logic                  host_we = 1'b0;
    logic [IDX_W-1:0]      host_idx = '0;
    logic [7:0]            host_wdata = '0;
    logic [NUM_REGS*8-1:0] regs_q;
    logic                  wr_valid;
    logic [IDX_W-1:0]      wr_idx;
    logic                  busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [IDX_W-1:0] wr_q[$];
    logic [7:0]       rd_q[$];
    logic             quiet_watch = 1'b0;
    int               quiet_viol  = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_target #(
        .ADDRESS    (7'h42),
        .NUM_REGS   (NUM_REGS),
        .FILTER_LEN (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .host_we    (host_we),
        .host_idx   (host_idx),
        .host_wdata (host_wdata),
        .regs_q     (regs_q),
        .wr_valid   (wr_valid),
        .wr_idx     (wr_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int k);
        return regs_q[k*8 +: 8];
    endfunction

    // Every bus write pulse must match the next expected index.
    always @(negedge clk) begin
        if (wr_valid) begin
            if (wr_q.size() == 0) check("wr_valid_unexpected", 32'(wr_idx), 32'hFFFF_FFFF);
            else check("wr_idx", 32'(wr_idx), 32'(wr_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (quiet_watch && (sda_oe || busy)) quiet_viol++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2*Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack_n);
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic host_write(input logic [IDX_W-1:0] idx, input logic [7:0] d);
        host_idx = idx; host_wdata = d; host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;

        // Reset values
        wait_clk(5);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_wr_idx", 32'(wr_idx), 0);
        check("rst_regs", 32'(|regs_q), 0);
        rst = 1'b0;
        wait_clk(20);
        check("post_rst_busy", 32'(busy), 0);

        // Pointer 3, two data bytes
        bus_start();
        put_byte(8'h84, ack); check("w1_addr_ack", 32'(ack), 0);
        check("w1_busy", 32'(busy), 1);
        put_byte(8'h03, ack); check("w1_ptr_ack", 32'(ack), 0);
        wr_q.push_back(IDX_W'(3));
        put_byte(8'hAA, ack); check("w1_d0_ack", 32'(ack), 0);
        wr_q.push_back(IDX_W'(4));
        put_byte(8'hBB, ack); check("w1_d1_ack", 32'(ack), 0);
        bus_stop();
        check("w1_reg3", 32'(reg_at(3)), 32'hAA);
        check("w1_reg4", 32'(reg_at(4)), 32'hBB);
        check("w1_busy_after_stop", 32'(busy), 0);

        // Pointer wrap
        bus_start();
        put_byte(8'h84, ack); check("w2_addr_ack", 32'(ack), 0);
        put_byte(8'h07, ack); check("w2_ptr_ack", 32'(ack), 0);
        wr_q.push_back(IDX_W'(7));
        put_byte(8'h11, ack);
        wr_q.push_back(IDX_W'(0));
        put_byte(8'h22, ack); check("w2_d1_ack", 32'(ack), 0);
        bus_stop();
        check("w2_reg7", 32'(reg_at(7)), 32'h11);
        check("w2_reg0", 32'(reg_at(0)), 32'h22);

        // Pointer set, repeated START, two-byte read with a host write during byte 2
        host_write(IDX_W'(2), 8'h5A);
        host_write(IDX_W'(3), 8'hC3);
        bus_start();
        put_byte(8'h84, ack); check("r1_addr_ack", 32'(ack), 0);
        put_byte(8'h02, ack); check("r1_ptr_ack", 32'(ack), 0);
        bus_start();
        put_byte(8'h85, ack); check("r1_raddr_ack", 32'(ack), 0);
        rd_q.push_back(8'h5A);
        get_byte(1'b0, d);
        check("r1_byte0", 32'(d), 32'(rd_q.pop_front()));
        rd_q.push_back(8'hC3);
        get_bit(b); d[7] = b;
        host_write(IDX_W'(3), 8'h0F);
        for (int i = 6; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(1'b1);
        check("r1_byte1", 32'(d), 32'(rd_q.pop_front()));
        wait_clk(Q);
        check("r1_released_after_nack", 32'(sda_oe), 0);
        check("r1_host_reg3", 32'(reg_at(3)), 32'h0F);
        bus_stop();
        check("r1_busy_after_stop", 32'(busy), 0);

        // Foreign address: no ACK, bus left alone
        quiet_viol = 0; quiet_watch = 1'b1;
        bus_start();
        put_byte(8'h90, ack); check("nm_addr_nack", 32'(ack), 1);
        put_byte(8'h55, ack); check("nm_data_nack", 32'(ack), 1);
        bus_stop();
        quiet_watch = 1'b0;
        check("nm_quiet", 32'(quiet_viol), 0);
        check("nm_reg5_untouched", 32'(reg_at(5)), 0);

        // One-clk SDA glitch while idle must not be taken as START
        quiet_viol = 0; quiet_watch = 1'b1;
        sda_m = 1'b0; wait_clk(1); sda_m = 1'b1; wait_clk(Q);
        put_byte(8'hC2, ack); check("gl_no_start_nack", 32'(ack), 1);
        wait_clk(Q);
        quiet_watch = 1'b0;
        check("gl_no_start_quiet", 32'(quiet_viol), 0);
        bus_stop();

        // SCL glitch mid-byte, then host/bus collision on the same index
        bus_start();
        put_byte(8'h84, ack); check("gc_addr_ack", 32'(ack), 0);
        put_byte(8'h05, ack); check("gc_ptr_ack", 32'(ack), 0);
        wr_q.push_back(IDX_W'(5));
        for (int i = 7; i >= 4; i--) put_bit(1'(8'h3C >> i));
        scl_m = 1'b1; wait_clk(1); scl_m = 1'b0; wait_clk(Q);
        for (int i = 3; i >= 0; i--) put_bit(1'(8'h3C >> i));
        get_bit(ack); check("gc_glitch_byte_ack", 32'(ack), 0);
        wr_q.push_back(IDX_W'(6));
        host_idx = IDX_W'(6); host_wdata = 8'hEE; host_we = 1'b1;
        fork
            put_byte(8'h77, ack);
            begin
                for (int k = 0; k < 2000 && !wr_valid; k++) @(negedge clk);
                host_we = 1'b0;
                check("gc_collision_seen", 32'(wr_valid), 1);
            end
        join
        check("gc_collide_ack", 32'(ack), 0);
        bus_stop();
        check("gc_reg5_glitch", 32'(reg_at(5)), 32'h3C);
        check("gc_reg6_bus_wins", 32'(reg_at(6)), 32'h77);

        // Reset during the 4th bit of a read, then a fresh transaction
        host_write(IDX_W'(1), 8'hE5);
        bus_start();
        put_byte(8'h84, ack);
        put_byte(8'h01, ack);
        bus_start();
        put_byte(8'h85, ack); check("rr_raddr_ack", 32'(ack), 0);
        for (int i = 0; i < 3; i++) get_bit(b);
        check("rr_bit4_driven", 32'(sda_oe), 1);
        rst = 1'b1;
        wait_clk(1);
        check("rr_sda_released", 32'(sda_oe), 0);
        check("rr_regs_cleared", 32'(|regs_q), 0);
        check("rr_busy_cleared", 32'(busy), 0);
        rst = 1'b0;
        wait_clk(10);
        bus_stop();
        bus_start();
        put_byte(8'h84, ack); check("rr_w_addr_ack", 32'(ack), 0);
        put_byte(8'h00, ack);
        wr_q.push_back(IDX_W'(0));
        put_byte(8'h9C, ack); check("rr_w_data_ack", 32'(ack), 0);
        bus_stop();
        check("rr_reg0", 32'(reg_at(0)), 32'h9C);
        bus_start();
        put_byte(8'h84, ack);
        put_byte(8'h00, ack);
        bus_start();
        put_byte(8'h85, ack);
        rd_q.push_back(8'h9C);
        get_byte(1'b1, d);
        check("rr_readback", 32'(d), 32'(rd_q.pop_front()));
        bus_stop();

        check("wr_queue_drained", 32'(wr_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
